// File: rtl/ssd_blink_driver_if.sv
// Display bus between the lock controller and the seven-segment driver:
// the packed display word in, active-low segments and anodes out.
interface ssd_blink_driver_if;
  logic [22:0] disps;
  logic [7:0]  seven_out;
  logic [3:0]  AN;

  modport master (output disps, input seven_out, input AN);
  modport slave  (input disps, output seven_out, output AN);
endinterface

// File: rtl/ssd_blink_driver.sv
// Four-digit common-anode display scanner with 1 Hz single-digit blink.
// Optional anti-ghosting anode gap at the start of each slot: define BLANK_GAP_EN.
module ssd_blink_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 50000000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  ssd_blink_driver_if.slave  bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCAN_W-1:0]  GAP_END    = SCAN_W'(GAP_CYCLES);
`ifdef BLANK_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic [22:0]        disps_q;
  logic [2:0]         code_prev_q;
  logic               run_q, run_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               hidden_q, hidden_d;
  logic [7:0]         seven_q, seven_d;
  logic [3:0]         an_q, an_d;

  logic [2:0] code;
  logic       code_changed;
  logic [4:0] char_sel;
  logic       blank_digit;
  logic       in_gap;

  function automatic logic [7:0] decode(input logic [4:0] c);
    logic [7:0] s;
    case (c)
      5'd0:  s = 8'h03;  5'd1:  s = 8'h9F;  5'd2:  s = 8'h25;  5'd3:  s = 8'h0D;
      5'd4:  s = 8'h99;  5'd5:  s = 8'h49;  5'd6:  s = 8'h41;  5'd7:  s = 8'h1F;
      5'd8:  s = 8'h01;  5'd9:  s = 8'h09;  5'd10: s = 8'h11;  5'd11: s = 8'hC1;
      5'd12: s = 8'h63;  5'd13: s = 8'h85;  5'd14: s = 8'h61;  5'd15: s = 8'h71;
      5'd16: s = 8'hFD;  5'd17: s = 8'hFF;  5'd18: s = 8'h03;  5'd19: s = 8'h31;
      5'd20: s = 8'h61;  5'd21: s = 8'hD5;  5'd22: s = 8'h63;  5'd23: s = 8'hE3;
      5'd24: s = 8'h49;  5'd25: s = 8'h85;  5'd26: s = 8'hC7;  5'd27: s = 8'hF5;
      5'd28: s = 8'hE1;  5'd29: s = 8'h89;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    code         = disps_q[22:20];
    code_changed = (code != code_prev_q);
    run_d        = 1'b1;
    scan_cnt_d   = scan_cnt_q;
    digit_d      = digit_q;
    blink_cnt_d  = blink_cnt_q;
    hidden_d     = hidden_q;

    // run_q holds counters for one cycle after reset so the first slot is full length
    if (run_q) begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d = '0;
        digit_d    = digit_q + 2'd1;
      end else begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end
    end

    if (code_changed) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (run_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        hidden_d    = ~hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    case (digit_q)
      2'd0:    char_sel = disps_q[19:15];
      2'd1:    char_sel = disps_q[14:10];
      2'd2:    char_sel = disps_q[9:5];
      default: char_sel = disps_q[4:0];
    endcase

    // A code change forces visibility in the same cycle it is seen
    blank_digit = hidden_q && !code_changed && code[2] && (code[1:0] == digit_q);
    in_gap      = GAP_EN && (scan_cnt_q < GAP_END);

    an_d    = 4'b1111;
    seven_d = 8'hFF;
    if (run_q && !in_gap) begin
      an_d    = ~(4'b1000 >> digit_q);
      seven_d = blank_digit ? 8'hFF : decode(char_sel);
    end
  end

  always_ff @(posedge clk) begin
    disps_q     <= bus.disps;
    code_prev_q <= disps_q[22:20];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 1'b0;
      scan_cnt_q  <= '0;
      digit_q     <= 2'd0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
      seven_q     <= 8'hFF;
      an_q        <= 4'b1111;
    end else begin
      run_q       <= run_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
      seven_q     <= seven_d;
      an_q        <= an_d;
    end
  end

  assign bus.seven_out = seven_q;
  assign bus.AN        = an_q;

endmodule

// File: tb/tb_ssd_blink_driver.sv
// Directed bench for ssd_blink_driver with a cycle-level reference model
// feeding an expected-output queue.
module tb_ssd_blink_driver;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 16;
  localparam int GAP_CYCLES = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ssd_blink_driver_if bus_if ();

  ssd_blink_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // Lit segments per character code, by letter name
  string glyph [32] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
    "g", "", "abcdef", "abefg", "adefg", "ceg", "adef", "def",
    "acdfg", "bcdeg", "cde", "eg", "defg", "bcdfg", "", ""};

  // Model state as seen just before the next rising edge
  logic        m_run = 1'b0;
  int          m_t = 0;
  int          m_bt = 0;
  logic [22:0] m_dq = '0;
  logic [2:0]  m_prev = '0;

  function automatic logic [7:0] segs(input string s);
    logic [7:0] v = 8'hFF;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": v[7] = 1'b0;
        "b": v[6] = 1'b0;
        "c": v[5] = 1'b0;
        "d": v[4] = 1'b0;
        "e": v[3] = 1'b0;
        "f": v[2] = 1'b0;
        "g": v[1] = 1'b0;
        default: ;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed seg=%h an=%b, expected seg=%h an=%b",
             tag, got[11:4], got[3:0], want[11:4], want[3:0]);
    end
  endtask

  task automatic cycle(input logic r, input logic [22:0] d);
    logic [11:0] want;
    logic [11:0] got;
    logic [2:0]  code;
    logic        changed;
    logic        gap;
    int          idx;
    logic [4:0]  ch;
    logic [7:0]  s;
    rst = r;
    bus_if.disps = d;
    code    = m_dq[22:20];
    changed = (code != m_prev);
`ifdef BLANK_GAP_EN
    gap = (m_t % SCAN_DIV) < GAP_CYCLES;
`else
    gap = 1'b0;
`endif
    want = {8'hFF, 4'b1111};
    if (!r && m_run && !gap) begin
      idx = (m_t / SCAN_DIV) % 4;
      ch  = m_dq[19 - 5*idx -: 5];
      s   = segs(glyph[ch]);
      if (code[2] && code[1:0] == idx[1:0] && !changed && ((m_bt / BLINK_DIV) % 2 == 1))
        s = 8'hFF;
      want = {s, ~(4'b1000 >> idx)};
    end
    exp_q.push_back(want);
    if (r) begin
      m_run = 1'b0;
      m_t   = 0;
      m_bt  = 0;
    end else begin
      if (m_run) m_t++;
      if (changed) m_bt = 0;
      else if (m_run) m_bt++;
      m_run = 1'b1;
    end
    m_prev = code;
    m_dq   = d;
    @(posedge clk);
    @(negedge clk);
    got = {bus_if.seven_out, bus_if.AN};
    check("scan", got, exp_q.pop_front());
  endtask

  task automatic run(input int n, input logic [22:0] d);
    for (int i = 0; i < n; i++) cycle(1'b0, d);
  endtask

  localparam logic [22:0] D_CLSD   = {3'b000, 5'd12, 5'd23, 5'd24, 5'd13};
  localparam logic [22:0] D_BLINK1 = {3'b101, 5'd16, 5'd1, 5'd17, 5'd17};
  localparam logic [22:0] D_BLINK2 = {3'b110, 5'd16, 5'd1, 5'd8, 5'd9};
  localparam logic [22:0] D_HIGH   = {3'b010, 5'd30, 5'd31, 5'd30, 5'd31};
  localparam logic [22:0] D_NOBL   = {3'b010, 5'd5, 5'd6, 5'd7, 5'd9};

  initial begin
    logic [11:0] seq [4] = '{{8'h63, 4'b0111}, {8'hE3, 4'b1011},
                             {8'h49, 4'b1101}, {8'h85, 4'b1110}};
    bit found;
    bus_if.disps = D_CLSD;
    @(negedge clk);

    // Reset hold, then the C L S d scan
    for (int i = 0; i < 3; i++) cycle(1'b1, D_CLSD);
    check("reset_state", {bus_if.seven_out, bus_if.AN}, {8'hFF, 4'b1111});
    for (int k = 0; k < 4; k++) begin
      run((k == 0) ? 3 : 4, D_CLSD);
      check($sformatf("clsd_digit%0d", k), {bus_if.seven_out, bus_if.AN}, seq[k]);
    end
    run(24, D_CLSD);

    // Every character code
    for (int k = 0; k < 8; k++)
      run(16, {3'b000, 5'(4*k), 5'(4*k+1), 5'(4*k+2), 5'(4*k+3)});

    // Blink on char1 across several half-periods
    run(80, D_BLINK1);

    // Move the blink target while the old one is hidden
    for (int k = 0; k < 64 && !(((m_bt / BLINK_DIV) % 2 == 1) && (m_bt % BLINK_DIV == 4)); k++)
      cycle(1'b0, D_BLINK1);
    run(70, D_BLINK2);

    // Out-of-range char codes and a non-blinking code
    run(40, D_HIGH);
    run(48, D_NOBL);

    // Reset while the third digit is lit
    found = 1'b0;
    for (int k = 0; k < 32 && !found; k++) begin
      if (bus_if.AN == 4'b1101) found = 1'b1;
      else cycle(1'b0, D_CLSD);
    end
    check("find_an1101", {8'h00, 3'b000, found}, 12'h001);
    cycle(1'b1, D_CLSD);
    check("midscan_reset", {bus_if.seven_out, bus_if.AN}, {8'hFF, 4'b1111});
    run(3, D_CLSD);
    check("restart_digit0", {bus_if.seven_out, bus_if.AN}, {8'h63, 4'b0111});
    run(40, D_CLSD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
